// File: rtl/sale_ctrl_if.sv
// Bundle of keypad, stock and transaction-status signals around the sale sequencer.
// Purely structural, no latency.
// No backpressure: keys are single-cycle pulses, status is level.
interface sale_ctrl_if;
    logic        sell_en;
    logic [15:0] key_edge;
    logic [3:0]  quant1;
    logic [3:0]  quant2;
    logic [3:0]  quant3;
    logic [3:0]  quant4;
    logic [3:0]  count1;
    logic [3:0]  count2;
    logic [3:0]  count3;
    logic [3:0]  count4;
    logic [2:0]  state;
    logic [1:0]  prod;
    logic [4:0]  paid;
    logic [3:0]  due;
    logic [4:0]  change;
    logic        dispense;
    logic        refund;
    logic        err;

    // Keypad / inventory side drives inputs and observes the sequencer.
    modport master (
        output sell_en, key_edge, quant1, quant2, quant3, quant4,
        input  count1, count2, count3, count4, state, prod, paid, due,
               change, dispense, refund, err
    );

    // Sequencer side.
    modport slave (
        input  sell_en, key_edge, quant1, quant2, quant3, quant4,
        output count1, count2, count3, count4, state, prod, paid, due,
               change, dispense, refund, err
    );
endinterface

// File: rtl/sale_ctrl.sv
// Sell-mode sequencer: select product, collect coins, dispense or refund, count sales.
// State/outputs registered; PAY entered one cycle after a valid key, DISPENSE/REFUND last one cycle.
// No backpressure: key pulses outside IDLE/PAY are dropped, one coin accepted per cycle.
module sale_ctrl #(
    parameter int PRICE1  = 3,
    parameter int PRICE2  = 5,
    parameter int PRICE3  = 7,
    parameter int PRICE4  = 9,
    parameter int TIMEOUT = 100000000,
    parameter int TW      = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    sale_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAY      = 3'd1,
        DISPENSE = 3'd2,
        REFUND   = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      prod_q, prod_d;
    logic [4:0]      paid_q, paid_d;
    logic [3:0]      due_q, due_d;
    logic [4:0]      change_q, change_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic [3:0][3:0] cnt_q, cnt_d;

    logic            sel_vld;
    logic [1:0]      sel_idx;
    logic [3:0]      sel_quant;
    logic [4:0]      coin_amt;
    logic [5:0]      paid_sum;
    logic            unused_keys;

    function automatic logic [3:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 4'(PRICE1);
            2'd1:    price_of = 4'(PRICE2);
            2'd2:    price_of = 4'(PRICE3);
            default: price_of = 4'(PRICE4);
        endcase
    endfunction

    // Keys that have no meaning to this block.
    assign unused_keys = ^{bus.key_edge[0], bus.key_edge[9:5], bus.key_edge[14:13]};

    // A selection counts only in sell mode with exactly one product key pressed.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        if (bus.sell_en) begin
            case (bus.key_edge[4:1])
                4'b0001: begin sel_vld = 1'b1; sel_idx = 2'd0; end
                4'b0010: begin sel_vld = 1'b1; sel_idx = 2'd1; end
                4'b0100: begin sel_vld = 1'b1; sel_idx = 2'd2; end
                4'b1000: begin sel_vld = 1'b1; sel_idx = 2'd3; end
                default: begin sel_vld = 1'b0; sel_idx = 2'd0; end
            endcase
        end
    end

    // Stock of the selected product and value of this cycle's coin (largest wins).
    always_comb begin
        case (sel_idx)
            2'd0:    sel_quant = bus.quant1;
            2'd1:    sel_quant = bus.quant2;
            2'd2:    sel_quant = bus.quant3;
            default: sel_quant = bus.quant4;
        endcase
        if (bus.key_edge[12])      coin_amt = 5'd10;
        else if (bus.key_edge[11]) coin_amt = 5'd5;
        else if (bus.key_edge[10]) coin_amt = 5'd1;
        else                       coin_amt = 5'd0;
    end

    assign paid_sum = {1'b0, paid_q} + {1'b0, coin_amt};

    // Next-state and datapath updates for the sale transaction.
    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        paid_d   = paid_q;
        due_d    = due_q;
        change_d = change_q;
        timer_d  = timer_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    change_d = 5'd0;
                    if (sel_quant == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        prod_d  = sel_idx;
                        due_d   = price_of(sel_idx);
                        paid_d  = 5'd0;
                        timer_d = '0;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (!bus.sell_en || bus.key_edge[15]) begin
                    state_d = REFUND;
                end else if (coin_amt != 5'd0) begin
                    paid_d  = paid_sum[5] ? 5'd31 : paid_sum[4:0];
                    timer_d = '0;
                end else if (paid_q >= {1'b0, due_q}) begin
                    state_d = DISPENSE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = REFUND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DISPENSE: begin
                change_d = paid_q - {1'b0, due_q};
                if (cnt_q[prod_q] != 4'hF) begin
                    cnt_d[prod_q] = cnt_q[prod_q] + 4'd1;
                end
                paid_d  = 5'd0;
                state_d = IDLE;
            end
            REFUND: begin
                change_d = paid_q;
                paid_d   = 5'd0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction datapath and sold counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= 2'd0;
            paid_q   <= 5'd0;
            due_q    <= 4'd0;
            change_q <= 5'd0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            paid_q   <= paid_d;
            due_q    <= due_d;
            change_q <= change_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.prod     = prod_q;
    assign bus.paid     = paid_q;
    assign bus.due      = due_q;
    assign bus.change   = change_q;
    assign bus.err      = err_q;
    assign bus.dispense = (state_q == DISPENSE);
    assign bus.refund   = (state_q == REFUND);
    assign bus.count1   = cnt_q[0];
    assign bus.count2   = cnt_q[1];
    assign bus.count3   = cnt_q[2];
    assign bus.count4   = cnt_q[3];

endmodule
